// File: rtl/chroni_pkg.sv
// Shared definitions for the chroni VRAM arbiter: bus widths, FSM encoding, grant kinds.
package chroni_pkg;

    localparam int VRAM_ADDR_W = 21;
    localparam int VRAM_DATA_W = 8;
    localparam int VID_OFS_W   = 13;
    localparam int VID_PAGE_W  = VRAM_ADDR_W - VID_OFS_W;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_ISSUE = 3'd1;
    localparam logic [2:0] ST_WAIT  = 3'd2;
    localparam logic [2:0] ST_RESP  = 3'd3;
    localparam logic [2:0] ST_GAP   = 3'd4;

    typedef enum logic [1:0] {
        GNT_VID    = 2'd0,
        GNT_CPU_RD = 2'd1,
        GNT_CPU_WR = 2'd2
    } grant_t;

endpackage

// File: rtl/chroni_vram_arbiter.sv
// Single-port VRAM arbiter: chroni video reads (priority) and CPU read/write,
// one operation in flight against a fixed-latency synchronous VRAM.
module chroni_vram_arbiter
    import chroni_pkg::*;
#(
    parameter int MEM_LATENCY  = 2,
    parameter int CPU_MAX_WAIT = 4
) (
    input  logic                   vga_clk,
    input  logic                   reset_n,
    input  logic [VID_OFS_W-1:0]   vid_addr,
    input  logic [VID_PAGE_W-1:0]  vid_page,
    input  logic                   vid_rd_req,
    output logic                   vid_rd_ack,
    output logic [VRAM_DATA_W-1:0] vid_data,
    input  logic [VRAM_ADDR_W-1:0] cpu_addr,
    input  logic [VRAM_DATA_W-1:0] cpu_wdata,
    input  logic                   cpu_re,
    input  logic                   cpu_we,
    output logic                   cpu_ack,
    output logic [VRAM_DATA_W-1:0] cpu_rdata,
    output logic [VRAM_ADDR_W-1:0] mem_addr,
    output logic [VRAM_DATA_W-1:0] mem_wdata,
    output logic                   mem_re,
    output logic                   mem_we,
    input  logic [VRAM_DATA_W-1:0] mem_rdata
);

    localparam logic [2:0] LAT_LOAD   = 3'(MEM_LATENCY - 1);
    localparam logic [2:0] MAX_WAIT_C = 3'(CPU_MAX_WAIT);

    logic [2:0] state;
    grant_t     grant;
    logic [2:0] lat_cnt;
    logic [2:0] starve_cnt;

    logic       cpu_req;
    logic       cpu_turn;
    logic       gnt_valid;
    grant_t     gnt_nx;

    assign cpu_req  = cpu_re | cpu_we;
    assign cpu_turn = cpu_req && (starve_cnt == MAX_WAIT_C);

    // Write beats read when the CPU raises both; the read stays pending.
    always_comb begin
        gnt_valid = 1'b1;
        gnt_nx    = GNT_VID;
        if (vid_rd_req && !cpu_turn)
            gnt_nx = GNT_VID;
        else if (cpu_we)
            gnt_nx = GNT_CPU_WR;
        else if (cpu_re)
            gnt_nx = GNT_CPU_RD;
        else
            gnt_valid = 1'b0;
    end

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            grant      <= GNT_VID;
            lat_cnt    <= '0;
            starve_cnt <= '0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            vid_data   <= '0;
            cpu_rdata  <= '0;
        end else begin
            case (state)
                // GAP is the bus-idle cycle after an ack; it arbitrates exactly
                // like IDLE so a held request restarts without a dead cycle.
                ST_IDLE, ST_GAP: begin
                    if (gnt_valid) begin
                        grant     <= gnt_nx;
                        mem_addr  <= (gnt_nx == GNT_VID) ? {vid_page, vid_addr} : cpu_addr;
                        mem_wdata <= cpu_wdata;
                        state     <= ST_ISSUE;
                    end else begin
                        state     <= ST_IDLE;
                    end
                    if (gnt_valid && gnt_nx == GNT_VID && cpu_req)
                        starve_cnt <= starve_cnt + 3'd1;
                    else
                        starve_cnt <= '0;
                end
                ST_ISSUE: begin
                    if (grant == GNT_CPU_WR) begin
                        state <= ST_RESP;
                    end else begin
                        lat_cnt <= LAT_LOAD;
                        state   <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (lat_cnt == 3'd0) begin
                        if (grant == GNT_VID)
                            vid_data  <= mem_rdata;
                        else
                            cpu_rdata <= mem_rdata;
                        state <= ST_RESP;
                    end else begin
                        lat_cnt <= lat_cnt - 3'd1;
                    end
                end
                ST_RESP: state <= ST_GAP;
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign mem_re     = (state == ST_ISSUE) && (grant != GNT_CPU_WR);
    assign mem_we     = (state == ST_ISSUE) && (grant == GNT_CPU_WR);
    assign vid_rd_ack = (state == ST_RESP)  && (grant == GNT_VID);
    assign cpu_ack    = (state == ST_RESP)  && (grant != GNT_VID);

endmodule

// File: doc/chroni_vram_arbiter.md
# chroni_vram_arbiter

Single-port VRAM arbiter that sits directly upstream of the chroni video fetch port. It serves chroni's text and font reads (`rd_req`/`rd_ack`, 13-bit offset plus 8-bit page) and CPU read/write accesses to the same memory. It issues one memory operation at a time to a synchronous, fixed-latency VRAM. Video has priority, and a starvation guard bounds CPU wait.

## Interface
Parameters:
- `MEM_LATENCY`, default 2: cycles from `mem_re` high to `mem_rdata` valid; legal range 1..7.
- `CPU_MAX_WAIT`, default 4: maximum consecutive video grants while a CPU request is pending.

Ports:
- `vga_clk` in 1: sole clock; every register is clocked on the rising edge.
- `reset_n` in 1: reset is asynchronous and active-low.
- `vid_addr` in 13: video byte offset (chroni `addr_out`).
- `vid_page` in 8: video page (chroni `addr_out_page`).
- `vid_rd_req` in 1: video read request, level.
- `vid_rd_ack` out 1: one-cycle pulse; `vid_data` is valid in that cycle.
- `vid_data` out 8: video read data.
- `cpu_addr` in 21: CPU VRAM address.
- `cpu_wdata` in 8: CPU write data.
- `cpu_re` in 1: CPU read request, level, held until ack.
- `cpu_we` in 1: CPU write request, level, held until ack.
- `cpu_ack` out 1: one-cycle completion pulse.
- `cpu_rdata` out 8: CPU read data, valid while `cpu_ack` is high after a read.
- `mem_addr` out 21: memory address, `{page, offset}`.
- `mem_wdata` out 8: memory write data.
- `mem_re` out 1: one-cycle read strobe.
- `mem_we` out 1: one-cycle write strobe.
- `mem_rdata` in 8: valid exactly `MEM_LATENCY` cycles after the `mem_re` cycle.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP, GAP.
- IDLE:
  - Samples requests and latches address and data into `mem_addr` and `mem_wdata`.
  - Records the grant (VID, CPU_RD or CPU_WR) and moves to ISSUE.
  - Stays in IDLE if nothing is requested.
- ISSUE: exactly one of `mem_re` or `mem_we` is high. A write goes to RESP. A read loads the latency counter and goes to WAIT.
- WAIT: counts `MEM_LATENCY`-1 further cycles, then captures `mem_rdata` into `vid_data` or `cpu_rdata` and goes to RESP.
- RESP: pulses `vid_rd_ack` or `cpu_ack`, then goes to GAP.
- GAP: one idle cycle so the requester's updated address is visible before the next sample. Then IDLE.
- Arbitration in IDLE:
  - Video wins unless the starvation counter equals `CPU_MAX_WAIT` and a CPU request is pending.
  - If `cpu_we` and `cpu_re` are both high, the write is performed; the read stays pending.
- Starvation counter, 3 bits:
  - Increments on each video grant while a CPU request is pending.
  - Clears on a CPU grant, or in any IDLE cycle with no CPU request.
- Address formation: video address = `{vid_page, vid_addr}`. No arithmetic is applied and there is no wrap logic.
- Requester drop: if a requester drops its request after grant, the operation still completes and the ack still pulses. The requester ignores it.
- Reset (asynchronous, including mid-operation):
  - State returns to IDLE, counters clear, and all outputs (strobes, acks, data, address) go to 0.
  - Any in-flight read is discarded and no ack is issued.

## Timing
- Read with request visible in cycle 0 (L = `MEM_LATENCY`):
  - `mem_re` is high in cycle 1.
  - `mem_rdata` is sampled in cycle 1+L.
  - The ack pulses in cycle 2+L.
  - The next request is sampled in cycle 3+L.
  - With L=2 this is 5 cycles per read.
- Write with request visible in cycle 0: `mem_we` is high in cycle 1, `cpu_ack` pulses in cycle 2, and the next request is sampled in cycle 3.
- Acks are never back-to-back. The minimum spacing between a request being sampled and the next sample is 3 cycles.
- `vid_data` and `cpu_rdata` hold their last value until the next capture.

## Structure
- Shared package `chroni_pkg` holds:
  - The FSM state encoding.
  - The grant enum (VID, CPU_RD, CPU_WR).
  - `VRAM_ADDR_W`=21, `VRAM_DATA_W`=8, `VID_OFS_W`=13.
- Single module with no sub-module. The latency counter and starvation counter are inline.

## Test plan
- Video read only: `vid_addr`=0x401, `vid_page`=0x00, memory returns 0x41. Required: `mem_addr`=0x00401 with `mem_re` in cycle 1, `vid_rd_ack` with `vid_data`=0x41 in cycle 4.
- Chained text-then-font read:
  - Requester holds `vid_rd_req` and changes `vid_addr` to 0x208 in the ack cycle.
  - Required: the second `mem_re` occurs 5 cycles after the first, with `mem_addr`=0x00208.
- Contention: `vid_rd_req` held continuously and `cpu_we` raised with addr 0x1F000, data 0xA5.
  - Required: exactly 4 video grants, then `mem_we` with 0x1F000/0xA5, then `cpu_ack`, then video resumes.
- Simultaneous `cpu_re` and `cpu_we` with no video request. Required: the write is performed first, then the read 3 cycles later, giving two separate `cpu_ack` pulses.
- `reset_n` low during WAIT. Required:
  - All outputs are 0 asynchronously.
  - No `vid_rd_ack` is issued.
  - After release, a new request is served with normal 4-cycle latency.
- L=1 build: read request in cycle 0 gives ack in cycle 3, with `vid_data` equal to the memory model value.
